// File: rtl/bus_steuerung.sv
// bus_steuerung: arbitrating bus controller between the CPU instruction/data ports, one
// synchronous single-port RAM and IO_KANAELE output registers. IO read-back: BUS_IO_RUECKLESEN_EN.
module bus_steuerung #(
    parameter int unsigned ADR_BITS   = 10,
    parameter int unsigned IO_KANAELE = 2,
    parameter int unsigned IO_BREITE  = 8
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [31:0]                     InstruktionAdresse,
    input  logic                            LeseInstruktion,
    input  logic [31:0]                     DatenAdresse,
    input  logic [31:0]                     DatenRaus,
    input  logic                            LeseDaten,
    input  logic                            SchreibeDaten,
    output logic [31:0]                     Instruktion,
    output logic [31:0]                     DatenRein,
    output logic                            InstruktionGeladen,
    output logic                            DatenGeladen,
    output logic                            DatenGespeichert,
    output logic [ADR_BITS-1:0]             RAMAdresse,
    output logic [31:0]                     RAMDatenInput,
    output logic                            RAMSchreibenAn,
    input  logic [31:0]                     RAMDatenOutput,
    output logic [IO_KANAELE*IO_BREITE-1:0] IOAusgang
);

    typedef enum logic [2:0] {
        LEERLAUF,
        I_LESEN,
        D_LESEN,
        D_SCHREIBEN,
        WARTEN
    } zustand_t;

    zustand_t                             r_zustand, w_zustand_d;
    logic                                 r_ist_instr, w_ist_instr_d;
    logic                                 r_auch_lesen, w_auch_lesen_d;
    logic [31:0]                          r_instruktion, w_instruktion_d;
    logic [31:0]                          r_daten_rein, w_daten_rein_d;
    logic                                 r_instr_geladen, w_instr_geladen_d;
    logic                                 r_geladen, w_geladen_d;
    logic                                 r_gespeichert, w_gespeichert_d;
    logic [ADR_BITS-1:0]                  r_ram_adr, w_ram_adr_d;
    logic [31:0]                          r_ram_wdat, w_ram_wdat_d;
    logic                                 r_ram_we, w_ram_we_d;
    logic [IO_KANAELE-1:0][IO_BREITE-1:0] r_io, w_io_d;

    logic        w_io_sel;
    logic [3:0]  w_io_kanal;
    logic [31:0] w_io_lesewert;
    logic        w_schreib;
    logic        w_lies;
    logic        w_instr;
    logic        w_unused_bits;

    assign w_io_sel      = DatenAdresse[31];
    assign w_io_kanal    = DatenAdresse[3:0];
    assign w_unused_bits = ^{InstruktionAdresse, DatenAdresse, DatenRaus};

    // A request is ignored in its own ack cycle: the requester only drops it on the next edge.
    assign w_schreib = SchreibeDaten & ~r_gespeichert;
    assign w_lies    = LeseDaten & ~r_geladen;
    assign w_instr   = LeseInstruktion & ~r_instr_geladen;

    always_comb begin
        w_io_lesewert = '0;
`ifdef BUS_IO_RUECKLESEN_EN
        for (int k = 0; k < int'(IO_KANAELE); k++) begin
            if (w_io_kanal == 4'(k)) begin
                w_io_lesewert[IO_BREITE-1:0] = r_io[k];
            end
        end
`endif
    end

    always_comb begin
        w_zustand_d       = r_zustand;
        w_ist_instr_d     = r_ist_instr;
        w_auch_lesen_d    = r_auch_lesen;
        w_instruktion_d   = r_instruktion;
        w_daten_rein_d    = r_daten_rein;
        w_instr_geladen_d = 1'b0;
        w_geladen_d       = 1'b0;
        w_gespeichert_d   = 1'b0;
        w_ram_adr_d       = r_ram_adr;
        w_ram_wdat_d      = r_ram_wdat;
        w_ram_we_d        = 1'b0;
        w_io_d            = r_io;

        case (r_zustand)
            LEERLAUF: begin
                if (w_schreib) begin
                    if (w_io_sel) begin
                        // Channels at or above IO_KANAELE match nothing: write is dropped.
                        for (int k = 0; k < int'(IO_KANAELE); k++) begin
                            if (w_io_kanal == 4'(k)) begin
                                w_io_d[k] = DatenRaus[IO_BREITE-1:0];
                            end
                        end
                        w_gespeichert_d = 1'b1;
                        w_geladen_d     = w_lies;
                    end else begin
                        w_ram_adr_d    = DatenAdresse[ADR_BITS-1:0];
                        w_ram_wdat_d   = DatenRaus;
                        w_ram_we_d     = 1'b1;
                        w_auch_lesen_d = w_lies;
                        w_zustand_d    = D_SCHREIBEN;
                    end
                end else if (w_lies) begin
                    if (w_io_sel) begin
                        w_daten_rein_d = w_io_lesewert;
                        w_geladen_d    = 1'b1;
                    end else begin
                        w_ram_adr_d   = DatenAdresse[ADR_BITS-1:0];
                        w_ist_instr_d = 1'b0;
                        w_zustand_d   = D_LESEN;
                    end
                end else if (w_instr) begin
                    w_ram_adr_d   = InstruktionAdresse[ADR_BITS-1:0];
                    w_ist_instr_d = 1'b1;
                    w_zustand_d   = I_LESEN;
                end
            end
            I_LESEN, D_LESEN: begin
                w_zustand_d = WARTEN;
            end
            WARTEN: begin
                if (r_ist_instr) begin
                    w_instruktion_d   = RAMDatenOutput;
                    w_instr_geladen_d = 1'b1;
                end else begin
                    w_daten_rein_d = RAMDatenOutput;
                    w_geladen_d    = 1'b1;
                end
                w_zustand_d = LEERLAUF;
            end
            D_SCHREIBEN: begin
                w_gespeichert_d = 1'b1;
                w_geladen_d     = r_auch_lesen;
                w_auch_lesen_d  = 1'b0;
                w_zustand_d     = LEERLAUF;
            end
            default: begin
                w_zustand_d = LEERLAUF;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_zustand       <= LEERLAUF;
            r_ist_instr     <= 1'b0;
            r_auch_lesen    <= 1'b0;
            r_instruktion   <= '0;
            r_daten_rein    <= '0;
            r_instr_geladen <= 1'b0;
            r_geladen       <= 1'b0;
            r_gespeichert   <= 1'b0;
            r_ram_adr       <= '0;
            r_ram_wdat      <= '0;
            r_ram_we        <= 1'b0;
            r_io            <= '0;
        end else begin
            r_zustand       <= w_zustand_d;
            r_ist_instr     <= w_ist_instr_d;
            r_auch_lesen    <= w_auch_lesen_d;
            r_instruktion   <= w_instruktion_d;
            r_daten_rein    <= w_daten_rein_d;
            r_instr_geladen <= w_instr_geladen_d;
            r_geladen       <= w_geladen_d;
            r_gespeichert   <= w_gespeichert_d;
            r_ram_adr       <= w_ram_adr_d;
            r_ram_wdat      <= w_ram_wdat_d;
            r_ram_we        <= w_ram_we_d;
            r_io            <= w_io_d;
        end
    end

    assign Instruktion        = r_instruktion;
    assign DatenRein          = r_daten_rein;
    assign InstruktionGeladen = r_instr_geladen;
    assign DatenGeladen       = r_geladen;
    assign DatenGespeichert   = r_gespeichert;
    assign RAMAdresse         = r_ram_adr;
    assign RAMDatenInput      = r_ram_wdat;
    assign RAMSchreibenAn     = r_ram_we;
    assign IOAusgang          = r_io;

endmodule

// File: tb/tb_bus_steuerung.sv
// Bench for bus_steuerung: vector table, hand-written corner sequences and randomized
// accesses checked against a word-level memory/IO model.
module tb_bus_steuerung;

    localparam int AdrBits = 10;
    localparam int IoK     = 2;
    localparam int IoB     = 8;
`ifdef BUS_IO_RUECKLESEN_EN
    localparam bit ReadBack = 1'b1;
`else
    localparam bit ReadBack = 1'b0;
`endif

    logic                Clock;
    logic                Reset;
    logic [31:0]         InstruktionAdresse;
    logic                LeseInstruktion;
    logic [31:0]         DatenAdresse;
    logic [31:0]         DatenRaus;
    logic                LeseDaten;
    logic                SchreibeDaten;
    logic [31:0]         Instruktion;
    logic [31:0]         DatenRein;
    logic                InstruktionGeladen;
    logic                DatenGeladen;
    logic                DatenGespeichert;
    logic [AdrBits-1:0]  RAMAdresse;
    logic [31:0]         RAMDatenInput;
    logic                RAMSchreibenAn;
    logic [31:0]         RAMDatenOutput;
    logic [IoK*IoB-1:0]  IOAusgang;

    bus_steuerung #(.ADR_BITS(AdrBits), .IO_KANAELE(IoK), .IO_BREITE(IoB)) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .InstruktionAdresse (InstruktionAdresse),
        .LeseInstruktion    (LeseInstruktion),
        .DatenAdresse       (DatenAdresse),
        .DatenRaus          (DatenRaus),
        .LeseDaten          (LeseDaten),
        .SchreibeDaten      (SchreibeDaten),
        .Instruktion        (Instruktion),
        .DatenRein          (DatenRein),
        .InstruktionGeladen (InstruktionGeladen),
        .DatenGeladen       (DatenGeladen),
        .DatenGespeichert   (DatenGespeichert),
        .RAMAdresse         (RAMAdresse),
        .RAMDatenInput      (RAMDatenInput),
        .RAMSchreibenAn     (RAMSchreibenAn),
        .RAMDatenOutput     (RAMDatenOutput),
        .IOAusgang          (IOAusgang)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Single-port synchronous RAM, read-before-write.
    logic [31:0] ram [1 << AdrBits];
    always @(posedge Clock) begin
        if (RAMSchreibenAn) ram[RAMAdresse] <= RAMDatenInput;
        RAMDatenOutput <= ram[RAMAdresse];
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // Reference model: word memory indexed modulo RAM depth, IO channel array.
    logic [31:0] ref_mem [1 << AdrBits];
    logic [7:0]  ref_io  [IoK];

    function automatic void model(input int op, input logic [31:0] adr, input logic [31:0] wdat,
                                  output int k, output logic [31:0] data);
        int idx;
        int ch;
        idx  = int'(adr % (32'd1 << AdrBits));
        ch   = int'(adr % 32'd16);
        data = '0;
        k    = 0;
        case (op)
            0: begin ref_mem[idx] = wdat; k = 1; end
            1, 2: begin data = ref_mem[idx]; k = 2; end
            3: begin if (ch < IoK) ref_io[ch] = wdat[7:0]; k = 0; end
            default: begin data = (ReadBack && ch < IoK) ? {24'h0, ref_io[ch]} : 32'h0; k = 0; end
        endcase
    endfunction

    // Drives requests, holds each through its ack cycle, drops it on the following edge,
    // and watches a fixed window so that spurious or repeated acks are counted in 'extra'.
    task automatic run_access(input bit w, input bit r, input bit i, input logic [31:0] dadr,
                              input logic [31:0] wdat, input logic [31:0] iadr,
                              output int kw, output int kr, output int ki,
                              output logic [31:0] rd, output logic [31:0] ins, output int extra);
        bit dw, dr, di;
        kw = -1; kr = -1; ki = -1; rd = '0; ins = '0; extra = 0;
        dw = 0; dr = 0; di = 0;
        DatenAdresse = dadr; DatenRaus = wdat; InstruktionAdresse = iadr;
        SchreibeDaten = w; LeseDaten = r; LeseInstruktion = i;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (dw) SchreibeDaten = 1'b0;
            if (dr) LeseDaten = 1'b0;
            if (di) LeseInstruktion = 1'b0;
            dw = 0; dr = 0; di = 0;
            if (DatenGespeichert) begin
                if (w && kw < 0) begin kw = c; dw = 1; end else extra++;
            end
            if (DatenGeladen) begin
                if (r && kr < 0) begin kr = c; dr = 1; rd = DatenRein; end else extra++;
            end
            if (InstruktionGeladen) begin
                if (i && ki < 0) begin ki = c; di = 1; ins = Instruktion; end else extra++;
            end
        end
        SchreibeDaten = 1'b0; LeseDaten = 1'b0; LeseInstruktion = 1'b0;
    endtask

    typedef struct {
        bit          w;
        bit          r;
        bit          i;
        logic [31:0] dadr;
        logic [31:0] wdat;
        logic [31:0] iadr;
        int          k;
        logic [31:0] data;
        logic [15:0] io;
    } vec_t;

    vec_t        vecs [11];
    int          kw, kr, ki, extra, ek, op, ch;
    logic [31:0] rd, ins, edata, adr, wd, exp_rein;
    logic [31:0] rb_a5, rb_3c;

    initial begin
        Reset = 1'b1;
        InstruktionAdresse = '0; LeseInstruktion = 1'b0;
        DatenAdresse = '0; DatenRaus = '0; LeseDaten = 1'b0; SchreibeDaten = 1'b0;
        for (int j = 0; j < IoK; j++) ref_io[j] = '0;

        rb_a5 = ReadBack ? 32'h0000_00A5 : 32'h0;
        rb_3c = ReadBack ? 32'h0000_003C : 32'h0;
        //            w  r  i  dadr          wdat          iadr   k  data          io
        vecs[0]  = '{1, 0, 0, 32'h0000_0005, 32'hDEADBEEF, 32'h0, 1, 32'h0,        16'h0000};
        vecs[1]  = '{0, 1, 0, 32'h0000_0005, 32'h0,        32'h0, 2, 32'hDEADBEEF, 16'h0000};
        vecs[2]  = '{1, 0, 0, 32'h8000_0001, 32'h0000_01A5, 32'h0, 0, 32'h0,       16'hA500};
        vecs[3]  = '{0, 1, 0, 32'h8000_0001, 32'h0,        32'h0, 0, rb_a5,        16'hA500};
        vecs[4]  = '{1, 0, 0, 32'h8000_000F, 32'h0000_005A, 32'h0, 0, 32'h0,       16'hA500};
        vecs[5]  = '{0, 1, 0, 32'h8000_000F, 32'h0,        32'h0, 0, 32'h0,        16'hA500};
        vecs[6]  = '{1, 0, 0, 32'h0000_0404, 32'h0000_0077, 32'h0, 1, 32'h0,       16'hA500};
        vecs[7]  = '{0, 1, 0, 32'h0000_0004, 32'h0,        32'h0, 2, 32'h0000_0077, 16'hA500};
        vecs[8]  = '{0, 0, 1, 32'h0,         32'h0,        32'h5, 2, 32'hDEADBEEF, 16'hA500};
        vecs[9]  = '{1, 0, 0, 32'h8000_0000, 32'hFFFF_FF3C, 32'h0, 0, 32'h0,       16'hA53C};
        vecs[10] = '{0, 1, 0, 32'h8000_0000, 32'h0,        32'h0, 0, rb_3c,        16'hA53C};

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset Instruktion", Instruktion, 32'h0);
        check("reset DatenRein", DatenRein, 32'h0);
        check("reset acks", {29'h0, InstruktionGeladen, DatenGeladen, DatenGespeichert}, 32'h0);
        check("reset RAMSchreibenAn", {31'h0, RAMSchreibenAn}, 32'h0);
        check("reset RAMAdresse", 32'(RAMAdresse), 32'h0);
        check("reset RAMDatenInput", RAMDatenInput, 32'h0);
        check("reset IOAusgang", 32'(IOAusgang), 32'h0);
        Reset = 1'b0;

        // Vector table
        for (int v = 0; v < 11; v++) begin
            run_access(vecs[v].w, vecs[v].r, vecs[v].i, vecs[v].dadr, vecs[v].wdat, vecs[v].iadr,
                       kw, kr, ki, rd, ins, extra);
            if (vecs[v].w) check($sformatf("vec%0d write ack cycle", v), kw, vecs[v].k);
            else if (vecs[v].r) check($sformatf("vec%0d read ack cycle", v), kr, vecs[v].k);
            else check($sformatf("vec%0d instr ack cycle", v), ki, vecs[v].k);
            if (vecs[v].r) check($sformatf("vec%0d DatenRein", v), rd, vecs[v].data);
            if (vecs[v].i) check($sformatf("vec%0d Instruktion", v), ins, vecs[v].data);
            check($sformatf("vec%0d IOAusgang", v), 32'(IOAusgang), 32'(vecs[v].io));
            check($sformatf("vec%0d stray acks", v), extra, 0);
        end
        exp_rein = rb_3c;

        // Write beats a simultaneous instruction fetch of the same word
        run_access(1, 0, 1, 32'h3, 32'h11, 32'h3, kw, kr, ki, rd, ins, extra);
        check("prio write ack cycle", kw, 1);
        check("prio instr ack cycle", ki, 4);
        check("prio Instruktion", ins, 32'h11);
        check("prio stray acks", extra, 0);

        // Read+write together: write only, both acks, DatenRein untouched
        run_access(1, 1, 0, 32'h10, 32'hCAFE0001, 32'h0, kw, kr, ki, rd, ins, extra);
        check("rw ram write ack", kw, 1);
        check("rw ram read ack", kr, 1);
        check("rw ram DatenRein held", rd, exp_rein);
        check("rw ram stray acks", extra, 0);
        run_access(0, 1, 0, 32'h10, 32'h0, 32'h0, kw, kr, ki, rd, ins, extra);
        check("rw ram readback", rd, 32'hCAFE0001);
        exp_rein = 32'hCAFE0001;
        run_access(1, 1, 0, 32'h8000_0001, 32'h7E, 32'h0, kw, kr, ki, rd, ins, extra);
        check("rw io write ack", kw, 0);
        check("rw io read ack", kr, 0);
        check("rw io DatenRein held", rd, exp_rein);
        check("rw io IOAusgang", 32'(IOAusgang), 32'h7E3C);

        // Reset one edge into a RAM read
        DatenAdresse = 32'h5; LeseDaten = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0; LeseDaten = 1'b0;
        check("midreset DatenRein", DatenRein, 32'h0);
        check("midreset IOAusgang", 32'(IOAusgang), 32'h0);
        check("midreset outputs", {RAMDatenInput | Instruktion | 32'(RAMAdresse)}, 32'h0);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            if (DatenGeladen || DatenGespeichert || InstruktionGeladen) extra++;
            @(posedge Clock);
            @(negedge Clock);
        end
        check("midreset no ack", extra, 0);
        for (int j = 0; j < IoK; j++) ref_io[j] = '0;
        run_access(0, 1, 0, 32'h5, 32'h0, 32'h0, kw, kr, ki, rd, ins, extra);
        check("postreset read ack", kr, 2);
        check("postreset read data", rd, 32'hDEADBEEF);

        // Reset on the edge where a registered RAM write lands
        DatenAdresse = 32'h20; DatenRaus = 32'hAB; SchreibeDaten = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0; SchreibeDaten = 1'b0;
        check("wreset RAMSchreibenAn", {31'h0, RAMSchreibenAn}, 32'h0);
        check("wreset no ack", {31'h0, DatenGespeichert}, 32'h0);
        run_access(0, 1, 0, 32'h20, 32'h0, 32'h0, kw, kr, ki, rd, ins, extra);
        check("wreset write landed", rd, 32'hAB);

        // Randomized accesses against the model; low words are preloaded first
        for (int a = 0; a < 16; a++) begin
            wd = $urandom;
            model(0, 32'(a), wd, ek, edata);
            run_access(1, 0, 0, 32'(a), wd, 32'h0, kw, kr, ki, rd, ins, extra);
            check($sformatf("preload%0d ack", a), kw, ek);
        end
        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 4));
            ch = int'($urandom_range(0, 15));
            wd = $urandom;
            if (op >= 3) adr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0) | 32'(ch);
            else if (op == 2) adr = ($urandom & 32'hFFFF_FC00) | 32'(ch);
            else adr = ($urandom & 32'h7FFF_FC00) | 32'(ch);
            model(op, adr, wd, ek, edata);
            run_access(op == 0 || op == 3, op == 1 || op == 4, op == 2, adr, wd, adr,
                       kw, kr, ki, rd, ins, extra);
            case (op)
                0, 3: check($sformatf("rnd%0d op%0d ack", t, op), kw, ek);
                1, 4: begin
                    check($sformatf("rnd%0d op%0d ack", t, op), kr, ek);
                    check($sformatf("rnd%0d op%0d DatenRein", t, op), rd, edata);
                end
                default: begin
                    check($sformatf("rnd%0d instr ack", t), ki, ek);
                    check($sformatf("rnd%0d Instruktion", t), ins, edata);
                end
            endcase
            check($sformatf("rnd%0d IOAusgang", t), 32'(IOAusgang), {16'h0, ref_io[1], ref_io[0]});
            check($sformatf("rnd%0d stray acks", t), extra, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
